// File: rtl/sm_debug_pkg.sv
// Shared encodings for the sm_debug_step run-control block: debugger
// command codes and FSM state codes.
package sm_debug_pkg;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_HALT = 2'b10;
  localparam logic [1:0] CMD_STEP = 2'b11;

  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;

endpackage

// File: rtl/sm_sync_pulse.sv
// Two-flop synchronizer followed by a rising-edge detector; emits a one-cycle
// pulse in the clk domain for each low-to-high transition of async_in.
module sm_sync_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic stage1;
  logic stage2;
  logic stage2_d;

  // synchronizer chain plus one delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1   <= 1'b0;
      stage2   <= 1'b0;
      stage2_d <= 1'b0;
    end else begin
      stage1   <= async_in;
      stage2   <= stage1;
      stage2_d <= stage2;
    end
  end

  assign pulse = stage2 & ~stage2_d;

endmodule

// File: rtl/sm_debug_step.sv
// CPU run-control FSM (HALT/RUN/STEP) producing a registered CPU clock enable.
// Optional macro SM_DEBUG_STEP_SYNC_EN synchronizes an asynchronous cmd_valid.
module sm_debug_step
  import sm_debug_pkg::*;
#(
  parameter int   CNT_W     = 16,
  parameter logic RESET_RUN = 1'b1
) (
  input  logic             clkIn,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd,
  input  logic [CNT_W-1:0] step_count,
  input  logic             halt_req,
  output logic             cpu_clk_en,
  output logic             halted,
  output logic             busy,
  output logic             cmd_drop,
  output logic [31:0]      en_cycles
);

  localparam logic [1:0]       RST_STATE = RESET_RUN ? ST_RUN : ST_HALT;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  logic             cmd_take;
  logic             is_run;
  logic             is_halt;
  logic             is_step;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             drop_nxt;

`ifdef SM_DEBUG_STEP_SYNC_EN
  sm_sync_pulse u_sync (
    .clk      (clkIn),
    .rst_n    (rst_n),
    .async_in (cmd_valid),
    .pulse    (cmd_take)
  );
`else
  assign cmd_take = cmd_valid;
`endif

  assign is_run  = cmd_take && (cmd == CMD_RUN);
  assign is_halt = cmd_take && (cmd == CMD_HALT);
  assign is_step = cmd_take && (cmd == CMD_STEP);

  // next-state logic: halt_req, then accepted command, then step expiry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    drop_nxt  = 1'b0;
    if (halt_req) begin
      state_nxt = ST_HALT;
      cnt_nxt   = CNT_ZERO;
      drop_nxt  = is_run || is_step;
    end else if (is_halt) begin
      state_nxt = ST_HALT;
      cnt_nxt   = CNT_ZERO;
    end else if (is_run) begin
      state_nxt = ST_RUN;
      cnt_nxt   = CNT_ZERO;
    end else if (is_step) begin
      state_nxt = ST_STEP;
      cnt_nxt   = (step_count == CNT_ZERO) ? CNT_ONE : step_count;
    end else begin
      case (state)
        ST_STEP: begin
          if (cnt == CNT_ONE) begin
            state_nxt = ST_HALT;
            cnt_nxt   = CNT_ZERO;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        ST_RUN, ST_HALT: begin
          state_nxt = state;
        end
        default: begin
          state_nxt = ST_HALT;
          cnt_nxt   = CNT_ZERO;
        end
      endcase
    end
  end

  // state, step counter, registered status outputs and enabled-cycle counter
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RST_STATE;
      cnt        <= CNT_ZERO;
      cpu_clk_en <= RESET_RUN;
      halted     <= ~RESET_RUN;
      busy       <= 1'b0;
      cmd_drop   <= 1'b0;
      en_cycles  <= 32'd0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cpu_clk_en <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
      halted     <= (state_nxt == ST_HALT);
      busy       <= (state_nxt == ST_STEP);
      cmd_drop   <= drop_nxt;
      en_cycles  <= en_cycles + {31'd0, cpu_clk_en};
    end
  end

endmodule

// File: tb/tb_sm_debug_step.sv
// Directed bench for sm_debug_step with a per-cycle reference model feeding a
// scoreboard queue; also handles the SM_DEBUG_STEP_SYNC_EN build.
module tb_sm_debug_step;
  import sm_debug_pkg::*;

`ifdef SM_DEBUG_STEP_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clkIn = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd;
  logic [15:0] step_count;
  logic        halt_req;
  logic        cpu_clk_en;
  logic        halted;
  logic        busy;
  logic        cmd_drop;
  logic [31:0] en_cycles;

  sm_debug_step #(.CNT_W(16), .RESET_RUN(1'b1)) dut (
    .clkIn      (clkIn),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .step_count (step_count),
    .halt_req   (halt_req),
    .cpu_clk_en (cpu_clk_en),
    .halted     (halted),
    .busy       (busy),
    .cmd_drop   (cmd_drop),
    .en_cycles  (en_cycles)
  );

  always #5 clkIn = ~clkIn;

  typedef struct packed {
    logic        clk_en;
    logic        halted;
    logic        busy;
    logic        drop;
    logic [31:0] en;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int en_seen  = 0;
  int busy_seen = 0;

  // reference model: mode 0 halt, 1 run, 2 step; m_left = enabled cycles left
  int          m_mode;
  int          m_left;
  logic        m_clk_en;
  logic        m_drop;
  logic [31:0] m_en;
  logic        h1, h2, h3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_mode   = 1;
    m_left   = 0;
    m_clk_en = 1'b1;
    m_drop   = 1'b0;
    m_en     = 32'd0;
    h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
  endtask

  task automatic model_edge();
    logic take;
    exp_t e;
`ifdef SM_DEBUG_STEP_SYNC_EN
    take = h2 && !h3 && (cmd != CMD_NOP);
    h3 = h2; h2 = h1; h1 = cmd_valid;
`else
    take = cmd_valid && (cmd != CMD_NOP);
`endif
    if (m_clk_en) m_en = m_en + 32'd1;
    m_drop = 1'b0;
    if (halt_req) begin
      m_drop = take && (cmd == CMD_RUN || cmd == CMD_STEP);
      m_mode = 0;
      m_left = 0;
    end else if (take && cmd == CMD_HALT) begin
      m_mode = 0;
      m_left = 0;
    end else if (take && cmd == CMD_RUN) begin
      m_mode = 1;
    end else if (take && cmd == CMD_STEP) begin
      m_mode = 2;
      m_left = (step_count == 16'd0) ? 1 : int'(step_count);
    end else if (m_mode == 2) begin
      m_left--;
      if (m_left == 0) m_mode = 0;
    end
    m_clk_en = (m_mode != 0);
    e.clk_en = m_clk_en;
    e.halted = (m_mode == 0);
    e.busy   = (m_mode == 2);
    e.drop   = m_drop;
    e.en     = m_en;
    sb.push_back(e);
  endtask

  task automatic step_clk();
    exp_t e;
    @(posedge clkIn);
    model_edge();
    #1;
    e = sb.pop_front();
    chk("cpu_clk_en", {31'd0, cpu_clk_en}, {31'd0, e.clk_en});
    chk("halted",     {31'd0, halted},     {31'd0, e.halted});
    chk("busy",       {31'd0, busy},       {31'd0, e.busy});
    chk("cmd_drop",   {31'd0, cmd_drop},   {31'd0, e.drop});
    chk("en_cycles",  en_cycles,           e.en);
    if (cpu_clk_en) en_seen++;
    if (busy) busy_seen++;
  endtask

  task automatic idle(input int k);
    cmd_valid = 1'b0;
    repeat (k) step_clk();
  endtask

  // pulse cmd_valid once and hold cmd until the command has been acted on
  task automatic issue(input logic [1:0] c, input logic [15:0] n);
    cmd        = c;
    step_count = n;
    cmd_valid  = 1'b1;
    step_clk();
    cmd_valid  = 1'b0;
    repeat (LAT) step_clk();
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd = CMD_NOP; step_count = 16'd0; halt_req = 1'b0;
    reset_model();
    #12;
    rst_n = 1'b1;
    chk("rst_clk_en", {31'd0, cpu_clk_en}, 32'd1);
    chk("rst_halted", {31'd0, halted},     32'd0);
    chk("rst_busy",   {31'd0, busy},       32'd0);
    chk("rst_drop",   {31'd0, cmd_drop},   32'd0);
    chk("rst_en",     en_cycles,           32'd0);

    // run out of reset for 10 cycles
    idle(10);
    chk("run10_en", en_cycles, 32'd10);

    // HALT then STEP 3
    issue(CMD_HALT, 16'd0);
    idle(2);
    en_seen = 0; busy_seen = 0;
    issue(CMD_STEP, 16'd3);
    idle(5);
    chk("step3_en_cycles", en_seen, 32'd3);
    chk("step3_busy_cycles", busy_seen, 32'd3);
    chk("step3_halted", {31'd0, halted}, 32'd1);

    // STEP 0 behaves as STEP 1
    en_seen = 0;
    issue(CMD_STEP, 16'd0);
    idle(4);
    chk("step0_en_cycles", en_seen, 32'd1);

    // STEP 5 cut short by HALT on the second stepping cycle
    en_seen = 0;
    issue(CMD_STEP, 16'd5);
    idle(1);
    issue(CMD_HALT, 16'd0);
    chk("step5_halt_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    idle(3);
    chk("step5_halt_en_cycles", en_seen, 32'(2 + LAT));
    en_seen = 0;
    issue(CMD_STEP, 16'd1);
    idle(3);
    chk("step1_en_cycles", en_seen, 32'd1);

    // RUN while halt_req is high is dropped
    halt_req = 1'b1;
    issue(CMD_RUN, 16'd0);
    chk("hreq_drop", {31'd0, cmd_drop}, 32'd1);
    chk("hreq_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    step_clk();
    chk("hreq_drop_pulse", {31'd0, cmd_drop}, 32'd0);
    halt_req = 1'b0;
    idle(3);
    chk("hreq_release_halted", {31'd0, halted}, 32'd1);
    issue(CMD_RUN, 16'd0);
    chk("run_after_hreq", {31'd0, cpu_clk_en}, 32'd1);

    // halt_req from RUN blocks, deassertion does not resume
    halt_req = 1'b1;
    step_clk();
    chk("hreq_run_clk_en", {31'd0, cpu_clk_en}, 32'd0);
    halt_req = 1'b0;
    idle(2);
    chk("hreq_run_stays", {31'd0, halted}, 32'd1);

`ifndef SM_DEBUG_STEP_SYNC_EN
    // back-to-back commands, later overrides earlier
    cmd_valid = 1'b1; cmd = CMD_STEP; step_count = 16'd4;
    step_clk();
    chk("b2b_step_busy", {31'd0, busy}, 32'd1);
    cmd = CMD_HALT;
    step_clk();
    chk("b2b_halt", {31'd0, cpu_clk_en}, 32'd0);
    cmd = CMD_RUN;
    step_clk();
    chk("b2b_run", {31'd0, cpu_clk_en}, 32'd1);
    cmd_valid = 1'b0;
    idle(2);
`else
    issue(CMD_RUN, 16'd0);
`endif

    // en_cycles wrap
    force dut.en_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.en_cycles;
    m_en = 32'hFFFF_FFFE;
    step_clk();
    chk("wrap_max", en_cycles, 32'hFFFF_FFFF);
    step_clk();
    chk("wrap_zero", en_cycles, 32'd0);

    // reset asserted mid-STEP
    issue(CMD_STEP, 16'd10);
    idle(2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_clk_en", {31'd0, cpu_clk_en}, 32'd1);
    chk("midrst_busy",   {31'd0, busy},       32'd0);
    chk("midrst_en",     en_cycles,           32'd0);
    @(posedge clkIn);
    #1;
    rst_n = 1'b1;
    reset_model();
    idle(3);

`ifdef SM_DEBUG_STEP_SYNC_EN
    // level held for 5 cycles: one command, acted on 2 edges after first sample
    issue(CMD_HALT, 16'd0);
    idle(2);
    cmd = CMD_RUN;
    cmd_valid = 1'b1;
    step_clk();
    chk("sync_e1", {31'd0, cpu_clk_en}, 32'd0);
    step_clk();
    chk("sync_e2", {31'd0, cpu_clk_en}, 32'd0);
    step_clk();
    chk("sync_e3", {31'd0, cpu_clk_en}, 32'd1);
    step_clk();
    step_clk();
    cmd_valid = 1'b0;
    idle(4);
    chk("sync_run_held", {31'd0, cpu_clk_en}, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_debug_step.md
# sm_debug_step

CPU run-control stage between the JTAG debug access port and the CPU core, in the `clkIn` domain. It turns debug commands (run, halt, step N) into the registered per-cycle enable `cpu_clk_en` that gates the CPU clock/enable. It also reports halt status and counts enabled cycles, so the debugger can single-step the CPU and then inspect registers through the boundary-scan chain.

## Interface
- `CNT_W`, 16: width of the step counter and of `step_count`.
- `RESET_RUN`, 1: 1 = leave reset in RUN; 0 = leave reset in HALT.
- `clkIn` input 1: the only clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `cmd_valid` input 1: command strobe, one cycle wide; level/edge source when `SM_DEBUG_STEP_SYNC_EN` is defined.
- `cmd` input 2: 00 NOP, 01 RUN, 10 HALT, 11 STEP.
- `step_count` input CNT_W: number of enabled cycles for STEP; 0 is treated as 1.
- `halt_req` input 1: external halt level, e.g. a breakpoint.
- `cpu_clk_en` output 1: registered CPU clock enable.
- `halted` output 1: high in HALT state.
- `busy` output 1: high in STEP state.
- `cmd_drop` output 1: one-cycle pulse when a RUN/STEP command is rejected.
- `en_cycles` output 32: count of cycles with `cpu_clk_en`=1; wraps at 2^32.

## Operation
- States: HALT, RUN, STEP. `cpu_clk_en` = (state==RUN || state==STEP), registered.
- Reset values:
  - state = RUN if `RESET_RUN` else HALT.
  - `cpu_clk_en` = `RESET_RUN`, `halted` = !`RESET_RUN`.
  - `busy` = 0, `cmd_drop` = 0, `en_cycles` = 0, step counter = 0.
- Transition priority, highest first:
  - `halt_req` forces HALT.
  - An accepted command applies next.
  - STEP counter expiry applies last.
- HALT command: go to HALT from any state. Any remaining step count is discarded.
- RUN command: go to RUN from any state.
- STEP command:
  - Load counter with max(`step_count`,1) and go to STEP from any state, including STEP (restart) and RUN.
  - In STEP, the counter decrements every cycle. When counter==1, the next state is HALT.
- `halt_req`=1 together with a RUN/STEP command:
  - Command is dropped and `cmd_drop` pulses.
  - State goes to or stays in HALT.
- `halt_req` only blocks. Deasserting it does not resume; an explicit RUN/STEP is required.
- NOP, and any `cmd_valid` while no command is presented, has no effect.
- `en_cycles` increments by 1 each cycle `cpu_clk_en`=1. It wraps from FFFF_FFFF to 0 and is cleared only by reset.
- Reset asserted mid-STEP: immediate return to the reset state. The counter is cleared.

## Timing
- Without the macro, `cmd_valid` sampled at edge t:
  - Next state, `cpu_clk_en`, `halted`, `busy` and `cmd_drop` all change at edge t.
  - Zero-wait handshake; a command is accepted every cycle.
- STEP N accepted at edge t:
  - `cpu_clk_en` is high for exactly N consecutive cycles after edge t.
  - It is low after edge t+N, when `halted` rises and `busy` falls.
- `halt_req` sampled high at edge t: `cpu_clk_en` is low after edge t. There is no combinational path from any input to any output.
- Back-to-back commands on consecutive cycles each take effect. A later command overrides an earlier one.

## Configuration
- `SM_DEBUG_STEP_SYNC_EN` defined:
  - `cmd_valid` is treated as asynchronous (driven from the TCK domain by update_dr).
  - It passes through a 2-flop synchronizer plus rising-edge detector, so one command is taken per rising edge.
  - This adds 2 cycles of latency: an edge registered at edge t is acted on at edge t+2.
  - `cmd` and `step_count` must be stable from the rising `cmd_valid` edge for at least 3 `clkIn` cycles.
  - Synchronizer flops reset to 0.
- Macro undefined:
  - `cmd_valid` is a synchronous one-cycle strobe, used directly.
  - No synchronizer flops exist.

## Structure
- Shared package `sm_debug_pkg` holds:
  - Command encodings `CMD_NOP`/`CMD_RUN`/`CMD_HALT`/`CMD_STEP`.
  - State encodings `ST_HALT`/`ST_RUN`/`ST_STEP`.
- One sub-module, `sm_sync_pulse`: 2-flop synchronizer with rising-edge pulse output, asynchronous active-low reset. It is instantiated only under `SM_DEBUG_STEP_SYNC_EN`.
- Everything else (state register, step counter, cycle counter) lives in `sm_debug_step`.

## Test plan
- Reset with `RESET_RUN`=1, run 10 cycles: `cpu_clk_en`=1, `halted`=0 throughout; `en_cycles`=10.
- HALT, then STEP with `step_count`=3: `cpu_clk_en` high exactly 3 cycles; `busy` high for 3 cycles; `halted` rises after; `en_cycles` +3.
- STEP with `step_count`=0 from HALT: exactly 1 enabled cycle, then HALT.
- STEP 5, then HALT on the 2nd stepping cycle: only 2 enabled cycles; `halted`=1 next cycle; a subsequent STEP 1 yields exactly 1 cycle.
- `halt_req`=1 while issuing RUN: `cmd_drop` pulses 1 cycle and `cpu_clk_en` stays 0. Drop `halt_req`: stays halted until RUN is issued.
- Macro defined: hold `cmd_valid` high for 5 cycles with RUN from HALT. Exactly one command is taken, `cpu_clk_en` rises 2 cycles after the first sampling edge. Also preload `en_cycles`=FFFF_FFFE (force) and confirm it wraps to 0.
